// File: rtl/alu_mdu.sv
// alu_mdu: parametrised ALU with registered outputs, a valid/ready handshake
// and an optional iterative multiply/divide unit (RV32M semantics).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  operation handshake; a, b, aluctr captured on accept
//   a, b                operands (WIDTH bits)
//   aluctr              5-bit op select, bit 4 selects the multiply/divide unit
//   out_valid, out_ready result handshake; res/zero held until taken
//   res                 registered result
//   zero                registered (a==b) of the accepted operands
//   busy                high while a MUL or DIV iteration is running
`timescale 1ns/1ps
module alu_mdu #(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0]   LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t state, state_nxt, go_state;

  logic                 accept;
  logic                 mdu_op, mul_op, div_op, div_zero, div_ovf, div_short;
  logic                 sa_in, sb_in;
  logic [WIDTH-1:0]     quick_res;

  logic [2*WIDTH-1:0]   prod_p0;
  logic [WIDTH-1:0]     mcand_p0, quo_p0, rem_p0, dvsr_p0;
  logic [SHW-1:0]       cnt_p0;
  logic [1:0]           op_p0;
  logic                 neg_p0, negr_p0;

  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   prod_nxt, prod_fix;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt, mul_res, div_res;

  function automatic logic [WIDTH-1:0] base_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs, ys;
    logic [SHW-1:0]          sh;
    xs = signed'(x);
    ys = signed'(y);
    sh = y[SHW-1:0];
    case (op)
      4'b0000: base_op = x + y;
      4'b0001: base_op = x << sh;
      4'b0010: base_op = {{(WIDTH-1){1'b0}}, (xs < ys)};
      4'b0011: base_op = {{(WIDTH-1){1'b0}}, (x < y)};
      4'b0100: base_op = x ^ y;
      4'b0101: base_op = x >> sh;
      4'b0110: base_op = x | y;
      4'b0111: base_op = x & y;
      4'b1000: base_op = x - y;
      4'b1101: base_op = xs >>> sh;
      4'b1111: base_op = y;
      default: base_op = ONES;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    mag = neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] mag2(input logic [2*WIDTH-1:0] x, input logic neg);
    mag2 = neg ? -x : x;
  endfunction

  // Stage p0 inputs: decode the offered operation
  always_comb begin
    mdu_op    = MDU_EN && aluctr[4] && !aluctr[3];
    mul_op    = mdu_op & ~aluctr[2];
    div_op    = mdu_op & aluctr[2];
    div_zero  = (b == '0);
    div_ovf   = ~aluctr[0] & (a == SMIN) & (b == ONES);
    div_short = div_op & (div_zero | div_ovf);
    if (mul_op) begin
      sa_in = a[WIDTH-1] & (aluctr[1] ^ aluctr[0]);
      sb_in = b[WIDTH-1] & ~aluctr[1] & aluctr[0];
    end else begin
      sa_in = a[WIDTH-1] & ~aluctr[0];
      sb_in = b[WIDTH-1] & ~aluctr[0];
    end
    if (!aluctr[4])
      quick_res = base_op(aluctr[3:0], a, b);
    else if (div_short)
      quick_res = div_zero ? (aluctr[1] ? a : ONES) : (aluctr[1] ? '0 : a);
    else
      quick_res = ONES;
    if (mul_op)
      go_state = MUL;
    else if (div_op && !div_short)
      go_state = DIV;
    else
      go_state = DONE;
  end

  // Stage p0 iteration: one shift-add or restoring-divide step per cycle
  always_comb begin
    mul_sum   = {1'b0, prod_p0[2*WIDTH-1:WIDTH]} + (prod_p0[0] ? {1'b0, mcand_p0} : '0);
    prod_nxt  = {mul_sum, prod_p0[WIDTH-1:1]};
    prod_fix  = mag2(prod_nxt, neg_p0);
    mul_res   = (op_p0 == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    div_trial = {rem_p0, quo_p0[WIDTH-1]} - {1'b0, dvsr_p0};
    if (div_trial[WIDTH]) begin
      rem_nxt = {rem_p0[WIDTH-2:0], quo_p0[WIDTH-1]};
      quo_nxt = {quo_p0[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = div_trial[WIDTH-1:0];
      quo_nxt = {quo_p0[WIDTH-2:0], 1'b1};
    end
    div_res = op_p0[1] ? mag(rem_nxt, negr_p0) : mag(quo_nxt, neg_p0);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      MUL, DIV: begin
        busy = 1'b1;
        if (cnt_p0 == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid & in_ready;
    if (accept) state_nxt = go_state;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p1: result register, written on quick accept or on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      res      <= '0;
      zero     <= 1'b0;
      prod_p0  <= '0;
      mcand_p0 <= '0;
      quo_p0   <= '0;
      rem_p0   <= '0;
      dvsr_p0  <= '0;
      cnt_p0   <= '0;
      op_p0    <= '0;
      neg_p0   <= 1'b0;
      negr_p0  <= 1'b0;
    end else if (accept) begin
      zero     <= (a == b);
      cnt_p0   <= '0;
      op_p0    <= aluctr[1:0];
      neg_p0   <= sa_in ^ sb_in;
      negr_p0  <= sa_in;
      mcand_p0 <= mag(a, sa_in);
      prod_p0  <= {{WIDTH{1'b0}}, mag(b, sb_in)};
      quo_p0   <= mag(a, sa_in);
      dvsr_p0  <= mag(b, sb_in);
      rem_p0   <= '0;
      if (go_state == DONE) res <= quick_res;
    end else if (state == MUL) begin
      prod_p0 <= prod_nxt;
      cnt_p0  <= cnt_p0 + SHW'(1);
      if (cnt_p0 == LAST) res <= mul_res;
    end else if (state == DIV) begin
      quo_p0 <= quo_nxt;
      rem_p0 <= rem_nxt;
      cnt_p0 <= cnt_p0 + SHW'(1);
      if (cnt_p0 == LAST) res <= div_res;
    end
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the CPU's single-cycle combinational ALU.
- Keeps the same 4-bit base op encodings and the `zero` (a==b) flag.
- Adds a configurable datapath width and registered outputs with a valid/ready handshake.
- Adds an optional iterative multiply/divide unit (RV32M semantics). It sits in the EX stage; the pipeline stalls while `in_ready` is low or `out_valid` is not yet asserted.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two, at least 8. Shift amount is b[SHW-1:0], where SHW = $clog2(WIDTH).
- MDU_EN, 1, 1 enables the op[4]=1 multiply/divide ops. 0 makes every op[4]=1 op return all-ones with basic-op latency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- aluctr  in  5  operation select; bit 4 selects the MDU.
- out_valid  out  1  res/zero are valid.
- out_ready  in  1  consumer takes the result.
- res  out  WIDTH  result, registered.
- zero  out  1  registered (a==b) of the accepted operands.
- busy  out  1  MUL or DIV iteration in progress.

Behaviour:
- Reset values, applied on the first rising edge with rst=1, any state:
  - FSM goes to IDLE.
  - out_valid=0, res=0, zero=0, busy=0.
  - All iteration registers are cleared.
  - Reset mid-MUL/DIV aborts the operation; the result is discarded.
  - in_ready=1 from the first cycle after rst deasserts.
- Accept: an operation is accepted on an edge where in_valid & in_ready. a, b, aluctr and (a==b) are captured.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back accepts.
- Base ops, aluctr[4]=0. Encodings and results are identical to the existing ALU:
  - 0000 add.
  - 0001 shl.
  - 0010 slt (signed).
  - 0011 sltu.
  - 0100 xor.
  - 0101 srl.
  - 0110 or.
  - 0111 and.
  - 1000 sub.
  - 1101 sra.
  - 1111 pass b.
  - Any other encoding: res = all-ones.
  - Add/sub wrap modulo 2^WIDTH.
  - Latency 1: IDLE goes to DONE, and out_valid is high in the cycle after accept.
- MDU ops, aluctr[4]=1:
  - 10000 mul (low WIDTH).
  - 10001 mulh (s×s).
  - 10010 mulhsu (s×u).
  - 10011 mulhu (u×u).
  - 10100 div.
  - 10101 divu.
  - 10110 rem.
  - 10111 remu.
  - 11xxx: all-ones, latency 1.
- FSM states IDLE, MUL, DIV, DONE:
  - MUL: 2*WIDTH-bit shift-add on operand magnitudes, one bit per cycle for WIDTH cycles. Sign correction is applied at the end. out_valid is asserted WIDTH+1 cycles after accept.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle for WIDTH cycles. Quotient sign = sa^sb; remainder sign = sign of a. Same WIDTH+1 latency.
  - Divide by zero: short-cut to DONE with latency 1. Quotient = all-ones; remainder = a.
  - Signed overflow (a = most-negative, b = -1, signed div/rem): short-cut to DONE with latency 1. Quotient = a; remainder = 0.
  - busy=1 in MUL and DIV only.
- DONE and output hold:
  - res, zero and out_valid hold stable while out_ready=0.
  - When out_ready=1 with no new accept, go to IDLE and drop out_valid the next cycle.
  - When out_ready=1 with a simultaneous accept, go directly to the new op's next state.
- Inputs are ignored while not in_ready; in_valid may drop freely.
- zero always reflects the captured a==b, independent of op.

Test Plan:
- Reset and idle: rst held 3 cycles mid-DIV (a=100, b=7) -> out_valid=0, res=0, busy=0, in_ready=1 the cycle after release, and no stale result appears.
- Base ops, WIDTH=32:
  - add 0xFFFFFFFF+1 -> res=0, zero=0, 1 cycle latency.
  - sra 0x80000000 by b=0x24 (amount 4) -> 0xF8000000.
  - slt -1 vs 1 -> 1.
  - sltu -1 vs 1 -> 0.
  - a=b=5 -> zero=1.
  - aluctr=01001 -> 0xFFFFFFFF.
- Multiply:
  - mulh 0x80000000 × 0x80000000 -> 0x40000000.
  - mulhsu -1 × 0xFFFFFFFF -> 0xFFFFFFFF.
  - mul 7×-3 -> 0xFFFFFFEB.
  - Each: out_valid exactly 33 cycles after accept, busy high 32 cycles.
- Divide:
  - div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF.
  - divu 100/0 -> 0xFFFFFFFF; remu x/0 -> x; both latency 1.
  - div 0x80000000/-1 -> 0x80000000; rem -> 0; both latency 1.
- Backpressure and back-to-back:
  - out_ready=0 for 5 cycles after a mul completes -> res stable, in_ready=0.
  - Then out_ready=1 with in_valid (add 2+3) on the same edge -> res=5, out_valid the next cycle with no bubble.
- MDU_EN=0 build: mul 3×4 -> res=0xFFFFFFFF, latency 1, busy never asserts.
